// File: rtl/led_rotation_monitor.sv
// led_rotation_monitor: classifies changes on an 8-bit rotating-LED bus, locks on regular rotation, flags faults
//   clk, rst (async, active-high), clr (sync clear back to IDLE), leds_in[7:0]
//   step_valid/step_dir (1=left) per legal step, period = cycles since previous change,
//   locked once LOCK_COUNT consecutive good steps were seen, error/error_code sticky first fault
//   (01 jump, 10 reversal, 11 period/stall).
//   Define MONITOR_AUTO_RECOVER_EN to let a legal step in FAULT restart tracking (error stays sticky).
module led_rotation_monitor #(
  parameter int EXPECTED_PERIOD = 2,
  parameter int TOL = 0,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [7:0]       leds_in,
  output logic             step_valid,
  output logic             step_dir,
  output logic [CNT_W-1:0] period,
  output logic             locked,
  output logic             error,
  output logic [1:0]       error_code
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int HI = EXPECTED_PERIOD + TOL;
  localparam int LO = EXPECTED_PERIOD > TOL ? EXPECTED_PERIOD - TOL : 0;
`ifdef MONITOR_AUTO_RECOVER_EN
  localparam bit RECOVER = 1'b1;
`else
  localparam bit RECOVER = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, TRACK, LOCKED, FAULT} state_t;
  state_t state;
  logic [7:0] prev_leds;
  logic [CNT_W-1:0] cyc_cnt;
  logic [GW-1:0] good_cnt, nxt_cnt;
  logic [31:0] cyc_ext;
  logic change, is_l, is_r, legal, in_win, stall, cont;
  always_comb begin
    change = leds_in != prev_leds;
    // 0x55/0xAA match both rotations; left takes priority
    is_l = leds_in == {prev_leds[6:0], prev_leds[7]};
    is_r = !is_l && leds_in == {prev_leds[0], prev_leds[7:1]};
    legal = change && (is_l || is_r);
    cyc_ext = 32'(cyc_cnt);
    in_win = cyc_ext >= 32'(LO) && cyc_ext <= 32'(HI);
    stall = !change && cyc_ext > 32'(HI);
    // a step only extends the run if a run exists, direction matches and timing fits
    cont = state == TRACK && good_cnt != '0 && is_l == step_dir && in_win;
    nxt_cnt = cont ? good_cnt + 1'b1 : GW'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      state <= IDLE;
      prev_leds <= '0;
      cyc_cnt <= '0;
      good_cnt <= '0;
      step_valid <= 1'b0;
      step_dir <= 1'b0;
      period <= '0;
      locked <= 1'b0;
      error <= 1'b0;
      error_code <= 2'b00;
    end else begin
      step_valid <= 1'b0;
      prev_leds <= leds_in;
      cyc_cnt <= change ? CNT_W'(1) : (&cyc_cnt ? cyc_cnt : cyc_cnt + 1'b1);
      if (legal && state != IDLE) begin
        step_valid <= 1'b1;
        step_dir <= is_l;
        period <= cyc_cnt;
      end
      case (state)
        IDLE: state <= TRACK;
        TRACK, FAULT:
          if (legal && (state == TRACK || RECOVER)) begin
            good_cnt <= nxt_cnt;
            state <= nxt_cnt == GW'(LOCK_COUNT) ? LOCKED : TRACK;
            locked <= nxt_cnt == GW'(LOCK_COUNT);
          end else if (change && state == TRACK) good_cnt <= '0;
        LOCKED:
          if (stall || (change && !(legal && is_l == step_dir && in_win))) begin
            state <= FAULT;
            locked <= 1'b0;
            error <= 1'b1;
            error_code <= !change ? 2'b11 : !legal ? 2'b01 : is_l != step_dir ? 2'b10 : 2'b11;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_led_rotation_monitor.sv
// tb_led_rotation_monitor: scoreboard bench for led_rotation_monitor
module tb_led_rotation_monitor;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic [7:0] leds_in = 8'h00;
  logic step_valid, step_dir, locked, error;
  logic [15:0] period;
  logic [1:0] error_code;
  int checks = 0, errors = 0;
  typedef struct {logic dir; int per; logic lk;} exp_t;
  exp_t q[$];
`ifdef MONITOR_AUTO_RECOVER_EN
  localparam bit R = 1'b1;
`else
  localparam bit R = 1'b0;
`endif
  led_rotation_monitor dut (
    .clk(clk), .rst(rst), .clr(clr), .leds_in(leds_in),
    .step_valid(step_valid), .step_dir(step_dir), .period(period),
    .locked(locked), .error(error), .error_code(error_code)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (step_valid) begin
      if (q.size() == 0) check("spurious_step", 32'(step_valid), 32'(0));
      else begin
        e = q.pop_front();
        check("step_dir", 32'(step_dir), 32'(e.dir));
        check("period", 32'(period), 32'(e.per));
        check("locked_at_step", 32'(locked), 32'(e.lk));
      end
    end
  endtask
  task automatic raw(input logic [7:0] v, input bit push_it, input bit dir, input int per,
                     input bit lk, input int hold);
    leds_in = v;
    if (push_it) q.push_back('{dir, per, lk});
    tick();
    check("step_seen", 32'(q.size()), 32'(0));
    repeat (hold - 1) tick();
  endtask
  task automatic st(input bit dir, input int hold, input int per, input bit lk);
    raw(dir ? {leds_in[6:0], leds_in[7]} : {leds_in[0], leds_in[7:1]}, 1'b1, dir, per, lk, hold);
  endtask
  task automatic flags(input string tag, input bit lk, input bit er, input logic [1:0] code);
    check({tag, "_locked"}, 32'(locked), 32'(lk));
    check({tag, "_error"}, 32'(error), 32'(er));
    check({tag, "_code"}, 32'(error_code), 32'(code));
  endtask
  task automatic lock_left();
    st(1'b1, 2, 2, 1'b0);
    st(1'b1, 2, 2, 1'b0);
    st(1'b1, 2, 2, 1'b0);
    st(1'b1, 2, 2, 1'b1);
  endtask
  task automatic relock();
    leds_in = 8'h1F;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    flags("clr", 1'b0, 1'b0, 2'b00);
    tick();
    tick();
    lock_left();
  endtask
  initial begin
    repeat (4) begin
      leds_in = {leds_in[6:0], ~leds_in[7]};
      tick();
      check("rst_step_valid", 32'(step_valid), 32'(0));
      check("rst_period", 32'(period), 32'(0));
      flags("rst", 1'b0, 1'b0, 2'b00);
    end
    rst = 1'b0;
    leds_in = 8'h1F;
    tick();
    tick();
    lock_left();
    flags("lock", 1'b1, 1'b0, 2'b00);
    repeat (5) st(1'b1, 2, 2, 1'b1);
    check("pre_jump_leds", 32'(leds_in), 32'h3E);
    raw(8'h55, 1'b0, 1'b0, 0, 1'b0, 1);
    flags("jump", 1'b0, 1'b1, 2'b01);
    tick();
    flags("jump_hold", 1'b0, 1'b1, 2'b01);
    leds_in = 8'h55;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    tick();
    raw(8'hAA, 1'b1, 1'b1, 2, 1'b0, 3);
    raw(8'h55, 1'b1, 1'b1, 3, 1'b0, 2);
    raw(8'hAA, 1'b1, 1'b1, 2, 1'b0, 2);
    raw(8'h55, 1'b1, 1'b1, 2, 1'b0, 2);
    raw(8'hAA, 1'b1, 1'b1, 2, 1'b1, 2);
    flags("ambig_lock", 1'b1, 1'b0, 2'b00);
    relock();
    st(1'b0, 1, 2, 1'b0);
    flags("reversal", 1'b0, 1'b1, 2'b10);
    repeat (3) tick();
    flags("reversal_sticky", 1'b0, 1'b1, 2'b10);
    st(1'b0, 2, 4, 1'b0);
    st(1'b0, 2, 2, 1'b0);
    st(1'b0, 2, 2, 1'b0);
    st(1'b0, 2, 2, R);
    flags("recover", R, 1'b1, 2'b10);
    relock();
    tick();
    st(1'b1, 2, 3, 1'b0);
    flags("period_fault", 1'b0, 1'b1, 2'b11);
    relock();
    tick();
    flags("stall_pre", 1'b1, 1'b0, 2'b00);
    tick();
    flags("stall", 1'b0, 1'b1, 2'b11);
    leds_in = {leds_in[6:0], leds_in[7]};
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_step_valid", 32'(step_valid), 32'(0));
    flags("clr_change", 1'b0, 1'b0, 2'b00);
    tick();
    check("idle_capture_step", 32'(step_valid), 32'(0));
    relock();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_step", 32'(step_valid), 32'(0));
    check("async_rst_period", 32'(period), 32'(0));
    flags("async_rst", 1'b0, 1'b0, 2'b00);
    rst = 1'b0;
    tick();
    check("queue_empty", 32'(q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
